// File: rtl/npu_queue_pkg.sv
// Shared defaults for the CPU<->NPU queue unit: bus width and queue depths.
package npu_queue_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CFG_DEPTH  = 8;
  localparam int DEF_IN_DEPTH   = 8;
  localparam int DEF_OUT_DEPTH  = 8;
endpackage

// File: rtl/npu_queue_if.sv
// CPU/NPU-facing bus of the queue unit. The unit itself attaches as slave.
// Handshake: a CPU op commits on a clock edge where it is asserted with iStall=0 and its queue is
// not full (cfg/enq) or not empty (deq); an NPU pop commits when its rd and valid are both 1 at an
// edge; an NPU push commits when iNpuOutWr=1 and oNpuOutFull=0, otherwise it is dropped.
interface npu_queue_if
  import npu_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  iStall;
  logic                  iFlush;
  logic                  iCpuCfgOp;
  logic                  iCpuEnqOp;
  logic                  iCpuDeqOp;
  logic [DATA_WIDTH-1:0] iCpuData;
  logic [DATA_WIDTH-1:0] oCpuDeqData;
  logic                  oNpuConfigFull;
  logic                  oNpuInputFull;
  logic                  oNpuOutputEmpty;
  logic                  oNpuCfgValid;
  logic [DATA_WIDTH-1:0] oNpuCfgData;
  logic                  iNpuCfgRd;
  logic                  oNpuInValid;
  logic [DATA_WIDTH-1:0] oNpuInData;
  logic                  iNpuInRd;
  logic                  iNpuOutWr;
  logic [DATA_WIDTH-1:0] iNpuOutData;
  logic                  oNpuOutFull;
  logic                  oOverflow;

  modport slave (
    input  iStall, iFlush, iCpuCfgOp, iCpuEnqOp, iCpuDeqOp, iCpuData,
    input  iNpuCfgRd, iNpuInRd, iNpuOutWr, iNpuOutData,
    output oCpuDeqData, oNpuConfigFull, oNpuInputFull, oNpuOutputEmpty,
    output oNpuCfgValid, oNpuCfgData, oNpuInValid, oNpuInData, oNpuOutFull, oOverflow
  );

  modport master (
    output iStall, iFlush, iCpuCfgOp, iCpuEnqOp, iCpuDeqOp, iCpuData,
    output iNpuCfgRd, iNpuInRd, iNpuOutWr, iNpuOutData,
    input  oCpuDeqData, oNpuConfigFull, oNpuInputFull, oNpuOutputEmpty,
    input  oNpuCfgValid, oNpuCfgData, oNpuInValid, oNpuInData, oNpuOutFull, oOverflow
  );
endinterface

// File: rtl/npu_fifo.sv
// Circular-buffer FIFO with show-ahead head, count-derived flags and a synchronous clear.
module npu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClear,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oHead,
  output logic             oFull,
  output logic             oEmpty,
  output logic             oPushDrop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  // Flags come from the registered count only, so a same-cycle pop never rescues a push on full.
  assign oFull     = (count == FULL_COUNT);
  assign oEmpty    = (count == '0);
  assign push_ok   = iPush && !oFull;
  assign pop_ok    = iPop && !oEmpty;
  assign oPushDrop = iPush && oFull;
  assign oHead     = oEmpty ? '0 : mem[rd_ptr];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iClear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is masked to zero while empty.
  always_ff @(posedge iClk) begin
    if (push_ok && !iClear) mem[wr_ptr] <= iPushData;
  end
endmodule

// File: rtl/npu_queue_unit.sv
// Config, input and output queues between the EX stage and the NPU core, plus the hazard status
// flags and a sticky output-overflow indicator.
module npu_queue_unit
  import npu_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CFG_DEPTH  = DEF_CFG_DEPTH,
  parameter int IN_DEPTH   = DEF_IN_DEPTH,
  parameter int OUT_DEPTH  = DEF_OUT_DEPTH
) (
  input logic        iClk,
  input logic        iRst_n,
  npu_queue_if.slave bus
);
  logic cfg_push;
  logic in_push;
  logic out_pop;
  logic cfg_empty;
  logic in_empty;
  logic out_drop;
  logic overflow;
  logic cfg_drop_unused;
  logic in_drop_unused;

  // CPU ops only commit in non-stalled cycles so an op held in EX is applied once.
  assign cfg_push = bus.iCpuCfgOp && !bus.iStall;
  assign in_push  = bus.iCpuEnqOp && !bus.iStall;
  assign out_pop  = bus.iCpuDeqOp && !bus.iStall;

  npu_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(CFG_DEPTH)) u_cfg_fifo (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iClear    (bus.iFlush),
    .iPush     (cfg_push),
    .iPushData (bus.iCpuData),
    .iPop      (bus.iNpuCfgRd),
    .oHead     (bus.oNpuCfgData),
    .oFull     (bus.oNpuConfigFull),
    .oEmpty    (cfg_empty),
    .oPushDrop (cfg_drop_unused)
  );

  npu_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iClear    (bus.iFlush),
    .iPush     (in_push),
    .iPushData (bus.iCpuData),
    .iPop      (bus.iNpuInRd),
    .oHead     (bus.oNpuInData),
    .oFull     (bus.oNpuInputFull),
    .oEmpty    (in_empty),
    .oPushDrop (in_drop_unused)
  );

  npu_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iClear    (bus.iFlush),
    .iPush     (bus.iNpuOutWr),
    .iPushData (bus.iNpuOutData),
    .iPop      (out_pop),
    .oHead     (bus.oCpuDeqData),
    .oFull     (bus.oNpuOutFull),
    .oEmpty    (bus.oNpuOutputEmpty),
    .oPushDrop (out_drop)
  );

  assign bus.oNpuCfgValid = !cfg_empty;
  assign bus.oNpuInValid  = !in_empty;
  assign bus.oOverflow    = overflow;

  // Overflow is sticky: only reset or flush clears it, and flush wins over a new drop.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)         overflow <= 1'b0;
    else if (bus.iFlush) overflow <= 1'b0;
    else if (out_drop)   overflow <= 1'b1;
  end
endmodule

// File: doc/npu_queue_unit.md
Name: npu_queue_unit

Overview:
- Owns the three CPU↔NPU queues: configuration, input and output.
- Produces the registered status flags the pipeline's hazard detection consumes to raise a full stall: config full, input full and output empty.
- Sits between the EX stage (NPU cfg/enq/deq ops) and the NPU core.
- CPU ops commit only in non-stalled cycles, so an op held in EX is never double-committed.

Parameters:
- DATA_WIDTH, 32, width of every queue entry and of CPU/NPU data buses.
- CFG_DEPTH, 8, config queue entries (power of two, ≥2).
- IN_DEPTH, 8, input queue entries (power of two, ≥2).
- OUT_DEPTH, 8, output queue entries (power of two, ≥2).

Ports:
- iClk  in  1  single clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iStall  in  1  pipeline full stall; when 1, all CPU-side ops are ignored.
- iFlush  in  1  synchronous clear of all three queues.
- iCpuCfgOp  in  1  EX holds an NPU config write.
- iCpuEnqOp  in  1  EX holds an NPU input enqueue.
- iCpuDeqOp  in  1  EX holds an NPU output dequeue.
- iCpuData  in  DATA_WIDTH  data for cfg/enq.
- oCpuDeqData  out  DATA_WIDTH  head of output queue (show-ahead).
- oNpuConfigFull  out  1  config queue full.
- oNpuInputFull  out  1  input queue full.
- oNpuOutputEmpty  out  1  output queue empty.
- oNpuCfgValid  out  1  config queue non-empty.
- oNpuCfgData  out  DATA_WIDTH  config queue head.
- iNpuCfgRd  in  1  NPU pops config head.
- oNpuInValid  out  1  input queue non-empty.
- oNpuInData  out  DATA_WIDTH  input queue head.
- iNpuInRd  in  1  NPU pops input head.
- iNpuOutWr  in  1  NPU pushes a result.
- iNpuOutData  in  DATA_WIDTH  result data.
- oNpuOutFull  out  1  output queue full (NPU back-pressure).
- oOverflow  out  1  sticky: NPU pushed into full output queue.

Behaviour:
- Reset (async, iRst_n=0):
  - All pointers and counts are 0.
  - oNpuOutputEmpty=1; all other flags, valids and oOverflow are 0.
  - Data outputs are 0.
  - Memory contents are don't-care.
- Each queue is a circular buffer.
  - Pointers are log2(DEPTH) bits and wrap DEPTH-1→0.
  - Occupancy count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0). Both derive from registered count only (no push/pop feed-through).
- Push accepted iff push request && !full. Pop accepted iff pop request && !empty.
  - Push on full is dropped; pointers and count are unchanged. A pop in the same cycle does not rescue it.
  - Pop on empty is ignored.
  - Accepted push+pop in the same cycle: both pointers advance and count is unchanged. The popped entry is the old head.
- CPU-side requests:
  - cfg push = iCpuCfgOp && !iStall.
  - input push = iCpuEnqOp && !iStall.
  - output pop = iCpuDeqOp && !iStall.
  - While a queue is full/empty, the hazard unit holds iStall=1, so the op retries and commits exactly once, in the first non-stalled cycle.
- NPU-side requests (iNpuCfgRd, iNpuInRd, iNpuOutWr) are not gated by iStall.
- Head outputs (oCpuDeqData, oNpuCfgData, oNpuInData) are combinational reads of mem[rd_ptr]. Data pushed at edge N is visible at the head after edge N if the queue was empty (1-cycle latency).
- Flags update on the edge that changes count.
- oOverflow sets when iNpuOutWr && oNpuOutFull. It clears only on reset or iFlush.
- iFlush=1: at the edge, all pointers, counts and oOverflow clear. Flush has priority over every push/pop in that cycle.
- Multiple CPU ops asserted together: each is applied to its own queue independently (decode guarantees at most one).

Decomposition:
- Shared package (npu_queue_pkg): default DATA_WIDTH and default depth constants.
- Sub-module npu_fifo (params WIDTH, DEPTH):
  - ports iClk, iRst_n, iClear, iPush, iPushData, iPop, oHead, oFull, oEmpty, oPushDrop;
  - instantiated three times;
  - top adds request gating and the sticky overflow.

Test Plan:
- Reset → oNpuOutputEmpty=1, oNpuConfigFull=0, oNpuInputFull=0, oOverflow=0, oNpuCfgValid=0, oNpuInValid=0.
- 8 enqueues of 0x10..0x17, iStall=0 → oNpuInputFull=1 after 8th edge. A 9th enq of 0x99 is dropped. NPU pops return 0x10..0x17 in order.
- Output queue holds 3 entries; iCpuDeqOp=1 with iStall=1 for 4 cycles, then iStall=0 for 1 cycle → exactly one pop; head advances from first to second entry.
- Input queue holds 4 entries; simultaneous enq 0xAA and iNpuInRd → count stays 4. Wrap-around over 20 push/pop pairs preserves FIFO order.
- Output queue full; iNpuOutWr with 0x55 → data dropped and oOverflow=1. It stays 1 after pops, clears on iFlush.
- iFlush asserted together with iCpuCfgOp while the config queue holds 5 entries → all queues empty next cycle; the cfg write is not stored.
